// File: rtl/ring_defs_pkg.sv
// Shared definitions for the ring code monitor:
// FSM state encoding, default ring width and a clog2 helper.
package ring_defs;

    typedef enum logic {
        UNSYNC = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int RING_N = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot decoder: reports the hot-bit position
// and whether exactly one bit is set.
module ring_onehot_decode
    import ring_defs::*;
#(
    parameter int N    = RING_N,
    parameter int IDXW = clog2(N)
) (
    input  logic [N-1:0]    din,
    output logic [IDXW-1:0] pos,
    output logic            legal
);

    int ones;

    always_comb begin
        ones = 0;
        pos  = '0;
        for (int i = 0; i < N; i++) begin
            if (din[i]) begin
                ones = ones + 1;
                pos  = IDXW'(i);
            end
        end
        legal = (ones == 1);
    end

endmodule

// File: rtl/ring_code_monitor.sv
// Consumer-side checker for a rotate-right one-hot ring counter:
// lock acquisition, lap counting and lock-loss diagnostics.
module ring_code_monitor
    import ring_defs::*;
#(
    parameter int N        = RING_N,
    parameter int SYNC_LEN = 2,
    parameter int LAPW     = 8,
    parameter int ERRW     = 8,
    localparam int IDXW    = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    din,
    input  logic            din_vld,
    output logic [IDXW-1:0] idx,
    output logic            locked,
    output logic            code_err,
    output logic            seq_err,
    output logic [LAPW-1:0] lap_cnt,
    output logic [ERRW-1:0] err_cnt
);

    state_e          state_q, state_d;
    logic            ref_vld_q, ref_vld_d;
    logic [N-1:0]    ref_q, ref_d;
    logic [3:0]      match_q, match_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            code_err_q, code_err_d;
    logic            seq_err_q, seq_err_d;
    logic [LAPW-1:0] lap_q, lap_d;
    logic [ERRW-1:0] err_q, err_d;

    logic [IDXW-1:0] pos;
    logic            legal;
    logic            in_seq;
    logic [3:0]      match_inc;

    ring_onehot_decode #(
        .N    (N),
        .IDXW (IDXW)
    ) u_dec (
        .din   (din),
        .pos   (pos),
        .legal (legal)
    );

    assign in_seq    = (din == {ref_q[0], ref_q[N-1:1]});
    assign match_inc = match_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        ref_vld_d  = ref_vld_q;
        ref_d      = ref_q;
        match_d    = match_q;
        idx_d      = idx_q;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        lap_d      = lap_q;
        err_d      = err_q;

        if (din_vld) begin
            if (!legal) begin
                code_err_d = 1'b1;
                ref_vld_d  = 1'b0;
                match_d    = '0;
                if (state_q == LOCKED) begin
                    state_d = UNSYNC;
                    if (err_q != '1) err_d = err_q + ERRW'(1);
                end
            end else begin
                ref_d     = din;
                ref_vld_d = 1'b1;
                idx_d     = pos;
                unique case (state_q)
                    UNSYNC: begin
                        if (ref_vld_q && in_seq) begin
                            match_d = match_inc;
                            if (match_inc == 4'(SYNC_LEN)) state_d = LOCKED;
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (in_seq) begin
                            // pos 0 closes one full revolution
                            if (pos == '0 && lap_q != '1) lap_d = lap_q + LAPW'(1);
                        end else begin
                            seq_err_d = 1'b1;
                            state_d   = UNSYNC;
                            match_d   = '0;
                            if (err_q != '1) err_d = err_q + ERRW'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= UNSYNC;
            ref_vld_q  <= 1'b0;
            ref_q      <= '0;
            match_q    <= '0;
            idx_q      <= '0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            lap_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ref_vld_q  <= ref_vld_d;
            ref_q      <= ref_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            lap_q      <= lap_d;
            err_q      <= err_d;
        end
    end

    assign idx      = idx_q;
    assign locked   = (state_q == LOCKED);
    assign code_err = code_err_q;
    assign seq_err  = seq_err_q;
    assign lap_cnt  = lap_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Directed bench for ring_code_monitor with a behavioural reference
// model checked every cycle plus hand-computed literal expectations.
module tb_ring_code_monitor;

    localparam int N        = 4;
    localparam int SYNC_LEN = 2;
    localparam int LAPW     = 8;
    localparam int ERRW     = 8;
    localparam int IDXW     = 2;
    localparam int LAPMAX   = 255;
    localparam int ERRMAX   = 255;

    logic            clk;
    logic            rst;
    logic [N-1:0]    din;
    logic            din_vld;
    logic [IDXW-1:0] idx;
    logic            locked;
    logic            code_err;
    logic            seq_err;
    logic [LAPW-1:0] lap_cnt;
    logic [ERRW-1:0] err_cnt;

    int n_chk;
    int n_err;
    bit chk_en;

    // model state (positions as integers, -1 = no reference)
    int m_ref_pos;
    int m_match;
    bit m_locked;
    int m_idx;
    bit m_ce;
    bit m_se;
    int m_lap;
    int m_err;

    ring_code_monitor #(
        .N        (N),
        .SYNC_LEN (SYNC_LEN),
        .LAPW     (LAPW),
        .ERRW     (ERRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .idx      (idx),
        .locked   (locked),
        .code_err (code_err),
        .seq_err  (seq_err),
        .lap_cnt  (lap_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: derived from the ring rules with integer positions
    always @(posedge clk) begin
        int ones;
        int p;
        bit insq;
        if (!rst) begin
            m_ref_pos = -1;
            m_match   = 0;
            m_locked  = 0;
            m_idx     = 0;
            m_ce      = 0;
            m_se      = 0;
            m_lap     = 0;
            m_err     = 0;
        end else if (!din_vld) begin
            m_ce = 0;
            m_se = 0;
        end else begin
            m_ce = 0;
            m_se = 0;
            ones = $countones(din);
            p = 0;
            for (int i = 0; i < N; i++) if (din[i]) p = i;
            if (ones != 1) begin
                m_ce = 1;
                if (m_locked) begin
                    m_locked = 0;
                    if (m_err < ERRMAX) m_err = m_err + 1;
                end
                m_ref_pos = -1;
                m_match   = 0;
            end else begin
                insq = (m_ref_pos >= 0) && (p == (m_ref_pos + N - 1) % N);
                if (m_locked) begin
                    if (insq) begin
                        if (p == 0 && m_lap < LAPMAX) m_lap = m_lap + 1;
                    end else begin
                        m_se     = 1;
                        m_locked = 0;
                        m_match  = 0;
                        if (m_err < ERRMAX) m_err = m_err + 1;
                    end
                end else if (insq) begin
                    m_match = m_match + 1;
                    if (m_match == SYNC_LEN) m_locked = 1;
                end else begin
                    m_match = 0;
                end
                m_ref_pos = p;
                m_idx     = p;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("idx", int'(idx), m_idx);
            check("locked", int'(locked), int'(m_locked));
            check("code_err", int'(code_err), int'(m_ce));
            check("seq_err", int'(seq_err), int'(m_se));
            check("lap_cnt", int'(lap_cnt), m_lap);
            check("err_cnt", int'(err_cnt), m_err);
            if (code_err && seq_err) check("both_pulses", 1, 0);
        end
    end

    task automatic cyc(input logic [N-1:0] w, input logic v, input logic r);
        @(negedge clk);
        din     = w;
        din_vld = v;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [N-1:0] w);
        cyc(w, 1'b1, 1'b1);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        chk_en  = 0;
        rst     = 1'b0;
        din     = '0;
        din_vld = 1'b0;

        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        chk_en = 1;
        check("rst_idx", int'(idx), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_lap", int'(lap_cnt), 0);
        check("rst_err", int'(err_cnt), 0);

        // acquire lock
        word(4'b0001);
        word(4'b1000);
        check("pre_lock", int'(locked), 0);
        word(4'b0100);
        check("lock_locked", int'(locked), 1);
        check("lock_idx", int'(idx), 2);

        // one lap while locked
        word(4'b0010);
        check("lap_idx1", int'(idx), 1);
        word(4'b0001);
        check("lap_idx0", int'(idx), 0);
        check("lap_cnt1", int'(lap_cnt), 1);
        word(4'b1000);
        check("lap_idx3", int'(idx), 3);

        // multi-hot while locked
        word(4'b0110);
        check("ce_pulse", int'(code_err), 1);
        check("ce_locked", int'(locked), 0);
        check("ce_err", int'(err_cnt), 1);
        check("ce_idx", int'(idx), 3);
        word(4'b0010);
        check("ce_one_cycle", int'(code_err), 0);
        word(4'b0001);
        word(4'b1000);
        check("relock", int'(locked), 1);
        check("relock_lap", int'(lap_cnt), 1);

        // out-of-sequence word at ref 1000
        word(4'b0010);
        check("se_pulse", int'(seq_err), 1);
        check("se_locked", int'(locked), 0);
        check("se_err", int'(err_cnt), 2);
        check("se_idx", int'(idx), 1);
        word(4'b0001);
        check("se_one_cycle", int'(seq_err), 0);
        word(4'b1000);
        check("se_relock", int'(locked), 1);

        // idle with garbage on the bus
        for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b0, 1'b1);
        check("idle_locked", int'(locked), 1);
        check("idle_idx", int'(idx), 3);
        check("idle_ce", int'(code_err), 0);
        word(4'b0100);
        check("resume_locked", int'(locked), 1);
        check("resume_idx", int'(idx), 2);

        // 300 laps saturate the lap counter
        for (int l = 0; l < 300; l++) begin
            word(4'b0010);
            word(4'b0001);
            word(4'b1000);
            word(4'b0100);
        end
        check("lap_sat", int'(lap_cnt), 255);
        check("lap_sat_locked", int'(locked), 1);

        // reset mid-lap
        word(4'b0010);
        cyc(4'b0001, 1'b1, 1'b0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_lap", int'(lap_cnt), 0);
        check("mid_rst_err", int'(err_cnt), 0);
        check("mid_rst_idx", int'(idx), 0);

        // all-zero word is illegal in UNSYNC, no err_cnt change
        word(4'b0000);
        check("zero_ce", int'(code_err), 1);
        check("zero_err", int'(err_cnt), 0);
        word(4'b1000);
        check("after_zero_idx", int'(idx), 3);

        // repeated word while locked
        word(4'b0100);
        word(4'b0010);
        check("rep_lock", int'(locked), 1);
        word(4'b0010);
        check("rep_se", int'(seq_err), 1);
        check("rep_err", int'(err_cnt), 1);

        cyc(4'b0000, 1'b0, 1'b1);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
